// File: rtl/seg7_scan_capture_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture_pkg
//   Shared definitions for the 7-segment scan capture block:
//   - NUM_DIGITS : number of multiplexed digits on the scan bus
//   - SEG7_GLYPH_0..F : active-high {g,f,e,d,c,b,a} patterns for hex digits
//   - scan_state_t : capture FSM states
//   - glyph_of() : nibble -> glyph lookup, shared by the decoder and any
//                  future display encoder check
// ---------------------------------------------------------------------------
package seg7_scan_capture_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG7_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG7_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG7_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG7_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG7_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG7_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG7_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG7_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG7_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG7_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG7_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG7_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG7_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG7_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG7_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG7_GLYPH_F = 7'h71;

  // WAIT   : scan idle (no digit selected)
  // SETTLE : a new {sel,seg} value is being qualified for stability
  // HOLD   : the settled value has been evaluated; ignore it until it changes
  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

  // Hex nibble to its active-high segment pattern.
  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = SEG7_GLYPH_0;
      4'h1:    g = SEG7_GLYPH_1;
      4'h2:    g = SEG7_GLYPH_2;
      4'h3:    g = SEG7_GLYPH_3;
      4'h4:    g = SEG7_GLYPH_4;
      4'h5:    g = SEG7_GLYPH_5;
      4'h6:    g = SEG7_GLYPH_6;
      4'h7:    g = SEG7_GLYPH_7;
      4'h8:    g = SEG7_GLYPH_8;
      4'h9:    g = SEG7_GLYPH_9;
      4'hA:    g = SEG7_GLYPH_A;
      4'hB:    g = SEG7_GLYPH_B;
      4'hC:    g = SEG7_GLYPH_C;
      4'hD:    g = SEG7_GLYPH_D;
      4'hE:    g = SEG7_GLYPH_E;
      default: g = SEG7_GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture_if
//   Bundles the scanned display bus and the word-level capture results.
//   Ports (signals):
//     seg_in      [7:0]  segment bus {dp,g,f,e,d,c,b,a} from the display driver
//     sel_in      [7:0]  digit select, bit k = digit k
//     value_out   [31:0] last complete frame, digit k -> [4k+3:4k]
//     frame_valid        one-cycle pulse when value_out updates
//     frame_count [15:0] frames published (wrapping)
//     err_sel            one-cycle pulse: settled select not one-hot
//     err_seg            one-cycle pulse: settled pattern not a hex glyph
//   Modports:
//     master : drives the scan bus, observes results (display side / bench)
//     slave  : the capture block
// ---------------------------------------------------------------------------
interface seg7_scan_capture_if;
  import seg7_scan_capture_pkg::*;

  logic [7:0]              seg_in;
  logic [NUM_DIGITS-1:0]   sel_in;
  logic [4*NUM_DIGITS-1:0] value_out;
  logic                    frame_valid;
  logic [15:0]             frame_count;
  logic                    err_sel;
  logic                    err_seg;

  modport master (
    output seg_in,
    output sel_in,
    input  value_out,
    input  frame_valid,
    input  frame_count,
    input  err_sel,
    input  err_seg
  );

  modport slave (
    input  seg_in,
    input  sel_in,
    output value_out,
    output frame_valid,
    output frame_count,
    output err_sel,
    output err_seg
  );

endinterface

// File: rtl/seg7_scan_capture_glyph.sv
// ---------------------------------------------------------------------------
// seg7_glyph_decode
//   Combinational decode of an active-high 7-segment pattern {g..a} back to
//   the hex nibble it displays. Any pattern that is not one of the sixteen
//   hex glyphs is reported as illegal (legal=0, nibble=0).
//   Ports:
//     pattern [6:0] in   active-high segment pattern {g,f,e,d,c,b,a}
//     legal         out  pattern matches a hex glyph
//     nibble  [3:0] out  decoded hex value (0 when illegal)
// ---------------------------------------------------------------------------
module seg7_glyph_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  // Search the glyph table; the sixteen glyphs are all distinct, so at most
  // one entry can match.
  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == glyph_of(4'(i))) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture
//   Receive side of a multiplexed 7-segment display. Watches the scanned
//   {sel,seg} bus, qualifies each digit for stability, decodes its glyph back
//   to a nibble and assembles the eight digits into a 32-bit word that is
//   published once per complete frame.
//   Parameters:
//     STABLE_CYCLES  identical consecutive samples needed to capture (>=2)
//     SEL_ACTIVE_LOW 1: sel bit = 0 selects the digit
//     SEG_ACTIVE_LOW 1: seg bit = 0 lights the segment
//   Ports:
//     clk_in  in  system clock (same clock as the display driver)
//     reset   in  asynchronous, active-high
//     bus     slave modport of seg7_scan_capture_if (scan in, word out)
// ---------------------------------------------------------------------------
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  seg7_scan_capture_if.slave   bus
);

  // The counter saturates one above the target so that a long-held value
  // hits the target exactly once.
  localparam int CNT_W = $clog2(STABLE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES + 1);

  localparam logic [NUM_DIGITS-1:0] SEL_INV = SEL_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0]            SEG_INV = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [NUM_DIGITS-1:0]   sel_raw_q;
  logic [7:0]              seg_raw_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic                    changed;
  logic [CNT_W-1:0]        stable_cnt;

  scan_state_t             state_q;
  scan_state_t             state_d;
  logic                    evaluate;

  logic                    sel_onehot;
  logic [DIGIT_W-1:0]      digit_idx;
  logic                    glyph_legal;
  logic [3:0]              glyph_nibble;
  logic                    capture;
  logic                    publish;

  logic [NUM_DIGITS-1:0]   digit_mask;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic                    frame_valid_q;
  logic [15:0]             frame_count_q;
  logic                    err_sel_q;
  logic                    err_seg_q;

  // Input register. Reset loads the inactive levels so that the bus looks
  // idle (no digit selected, all segments dark) straight out of reset.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sel_raw_q <= SEL_INV;
      seg_raw_q <= SEG_INV;
    end else begin
      sel_raw_q <= bus.sel_in;
      seg_raw_q <= bus.seg_in;
    end
  end

  // Polarity normalisation; everything downstream works active-high.
  // A change is detected on the raw values entering the register so that
  // the counter tracks how long the registered sample has been held.
  assign sel_q    = sel_raw_q ^ SEL_INV;
  assign seg_q    = seg_raw_q ^ SEG_INV;
  assign sel_next = bus.sel_in ^ SEL_INV;
  assign changed  = ({bus.sel_in, bus.seg_in} != {sel_raw_q, seg_raw_q});

  // Stability counter: number of consecutive identical samples held in the
  // input register (dp included, so a dp-only change still restarts it).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
    end else if (changed) begin
      stable_cnt <= CNT_W'(1);
    end else if (stable_cnt != CNT_MAX) begin
      stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A settled value is evaluated once, on the cycle its
  // count reaches the target; HOLD then ignores it. A change in the input
  // overrides everything: a fresh value always restarts qualification,
  // unless the scan went idle. The evaluation still happens when the input
  // changes on that very edge, because the sample being judged was held
  // long enough.
  always_comb begin
    state_d  = state_q;
    evaluate = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (sel_q != '0) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stable_cnt == CNT_TARGET) begin
          evaluate = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_d = ST_HOLD;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
    if (changed) begin
      state_d = (sel_next == '0) ? ST_WAIT : ST_SETTLE;
    end
  end

  // Which digit the settled sample addresses; only meaningful when one-hot.
  always_comb begin
    digit_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_q[k]) digit_idx = DIGIT_W'(k);
    end
  end

  assign sel_onehot = $onehot(sel_q);

  seg7_glyph_decode u_glyph_decode (
    .pattern (seg_q[6:0]),
    .legal   (glyph_legal),
    .nibble  (glyph_nibble)
  );

  assign capture = evaluate && sel_onehot && glyph_legal;
  assign publish = &digit_mask;

  // Frame assembly and publication. When the mask is full it is published
  // on the next edge from the old shadow; a capture on that same edge is
  // credited to the following frame (mask cleared, then its bit set).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      digit_mask    <= '0;
      shadow        <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= 16'h0000;
      err_sel_q     <= 1'b0;
      err_seg_q     <= 1'b0;
    end else begin
      frame_valid_q <= publish;
      err_sel_q     <= evaluate && !sel_onehot;
      err_seg_q     <= evaluate && !glyph_legal;
      if (publish) begin
        value_q       <= shadow;
        frame_count_q <= frame_count_q + 16'd1;
      end
      digit_mask <= (publish ? '0 : digit_mask)
                  | (capture ? (NUM_DIGITS'(1) << digit_idx) : '0);
      if (capture) begin
        shadow[4*digit_idx +: 4] <= glyph_nibble;
      end
    end
  end

  assign bus.value_out   = value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_count = frame_count_q;
  assign bus.err_sel     = err_sel_q;
  assign bus.err_seg     = err_seg_q;

endmodule
